// File: rtl/step_pulse_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : step_pulse_monitor_if
// Description : Pin bundle between a step/dir/microstep source and the
//               step_pulse_monitor. The master side drives the motor pins and
//               the clear. The slave side is the monitor, which returns the
//               reconstructed motion state.
// Revision    : 1.0 - initial release
// ============================================================================
interface step_pulse_monitor_if #(
  parameter int C_POSITION_WIDTH    = 32,
  parameter int C_STEP_NUMBER_WIDTH = 16,
  parameter int C_PERIOD_WIDTH      = 16,
  parameter int C_MICROSTEP_WIDTH   = 3
);
  logic                           i_drive;
  logic                           i_dir;
  logic [C_MICROSTEP_WIDTH-1:0]   i_ms;
  logic                           i_zpd;
  logic                           i_clear;
  logic [C_POSITION_WIDTH-1:0]    o_position;
  logic [C_STEP_NUMBER_WIDTH-1:0] o_step_cnt;
  logic [C_PERIOD_WIDTH-1:0]      o_period;
  logic                           o_period_valid;
  logic                           o_moving;
  logic                           o_reverse;
  logic                           o_stall;
  logic                           o_zero_hit;
  logic                           o_dir_err;

  modport master (
    output i_drive, i_dir, i_ms, i_zpd, i_clear,
    input  o_position, o_step_cnt, o_period, o_period_valid, o_moving,
           o_reverse, o_stall, o_zero_hit, o_dir_err
  );

  modport slave (
    input  i_drive, i_dir, i_ms, i_zpd, i_clear,
    output o_position, o_step_cnt, o_period, o_period_valid, o_moving,
           o_reverse, o_stall, o_zero_hit, o_dir_err
  );
endinterface
`default_nettype wire

// File: rtl/step_pulse_monitor.sv
`default_nettype none
// ============================================================================
// Module      : step_pulse_monitor
// Description : Receive-side monitor for step/dir/microstep pins. It
//               reconstructs the signed position in finest-microstep units,
//               the raw step count and the step period. It also flags
//               reversals and stalls, and re-zeroes on the zero-position
//               detector.
//               Optional macro STEP_MON_DIR_CHECK_EN adds a sticky
//               direction-setup violation flag.
// Revision    : 1.0 - initial release
// ============================================================================
module step_pulse_monitor #(
  parameter int C_POSITION_WIDTH    = 32,
  parameter int C_STEP_NUMBER_WIDTH = 16,
  parameter int C_PERIOD_WIDTH      = 16,
  parameter int C_MICROSTEP_WIDTH   = 3,
  parameter int C_MS_MAX            = 5,
  parameter int C_SYNC_STAGES       = 2,
  parameter int C_STALL_CYCLES      = 50000,
  parameter int C_DIR_SETUP         = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  step_pulse_monitor_if.slave  pins
);

  localparam int                           C_CNT_W       = $clog2(C_STALL_CYCLES + 1);
  localparam logic [C_CNT_W-1:0]           C_STALL_CNT   = C_CNT_W'(C_STALL_CYCLES);
  localparam logic [C_MICROSTEP_WIDTH-1:0] C_MS_MAX_CODE = C_MICROSTEP_WIDTH'(C_MS_MAX);
  localparam logic [C_POSITION_WIDTH-1:0]  C_POS_ONE     = C_POSITION_WIDTH'(1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_MOVING = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [C_SYNC_STAGES-1:0]                         drive_sync_q, dir_sync_q, zpd_sync_q;
  logic [C_SYNC_STAGES-1:0][C_MICROSTEP_WIDTH-1:0]  ms_sync_q;
  logic                                             drive_dly_q, zpd_dly_q;

  logic                           drive_s, dir_s, zpd_s;
  logic [C_MICROSTEP_WIDTH-1:0]   ms_s;
  logic                           step_rise, zpd_rise, timeout;
  logic [C_POSITION_WIDTH-1:0]    inc;
  logic [C_PERIOD_WIDTH-1:0]      period_sat;

  logic [C_POSITION_WIDTH-1:0]    pos_q, pos_d;
  logic [C_STEP_NUMBER_WIDTH-1:0] step_cnt_q, step_cnt_d;
  logic [C_PERIOD_WIDTH-1:0]      period_q, period_d;
  logic [C_CNT_W-1:0]             per_cnt_q, per_cnt_d;
  logic                           period_valid_q, period_valid_d;
  logic                           reverse_q, reverse_d;
  logic                           stall_q, stall_d;
  logic                           zero_hit_q, zero_hit_d;
  logic                           prev_dir_q, prev_dir_d;

  // Equal-depth synchronisers keep dir/ms aligned with the drive edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drive_sync_q <= '0;
      dir_sync_q   <= '0;
      zpd_sync_q   <= '0;
      ms_sync_q    <= '0;
      drive_dly_q  <= 1'b0;
      zpd_dly_q    <= 1'b0;
    end else begin
      drive_sync_q <= {drive_sync_q[C_SYNC_STAGES-2:0], pins.i_drive};
      dir_sync_q   <= {dir_sync_q[C_SYNC_STAGES-2:0], pins.i_dir};
      zpd_sync_q   <= {zpd_sync_q[C_SYNC_STAGES-2:0], pins.i_zpd};
      ms_sync_q    <= {ms_sync_q[C_SYNC_STAGES-2:0], pins.i_ms};
      drive_dly_q  <= drive_s;
      zpd_dly_q    <= zpd_s;
    end
  end

  assign drive_s   = drive_sync_q[C_SYNC_STAGES-1];
  assign dir_s     = dir_sync_q[C_SYNC_STAGES-1];
  assign zpd_s     = zpd_sync_q[C_SYNC_STAGES-1];
  assign ms_s      = ms_sync_q[C_SYNC_STAGES-1];
  assign step_rise = drive_s & ~drive_dly_q;
  assign zpd_rise  = zpd_s & ~zpd_dly_q;
  assign timeout   = (per_cnt_q == C_STALL_CNT);

  // Position increment for the sampled microstep code; out-of-range codes step by one LSB
  always_comb begin
    inc = C_POS_ONE;
    if (ms_s <= C_MS_MAX_CODE) begin
      inc = C_POS_ONE << (C_MS_MAX_CODE - ms_s);
    end
  end

  generate
    if (C_CNT_W > C_PERIOD_WIDTH) begin : g_period_sat
      assign period_sat = (|per_cnt_q[C_CNT_W-1:C_PERIOD_WIDTH]) ? '1 : per_cnt_q[C_PERIOD_WIDTH-1:0];
    end else begin : g_period_ext
      assign period_sat = C_PERIOD_WIDTH'(per_cnt_q);
    end
  endgenerate

  // Motion state: a step starts motion; a full stall interval without steps ends it
  always_comb begin
    state_d = state_q;
    stall_d = 1'b0;
    if (pins.i_clear) begin
      state_d = ST_IDLE;
    end else if (step_rise) begin
      state_d = ST_MOVING;
    end else if ((state_q == ST_MOVING) && timeout) begin
      state_d = ST_IDLE;
      stall_d = 1'b1;
    end
  end

  // Position, step count, period and strobes; clear beats zero, zero beats step
  always_comb begin
    pos_d          = pos_q;
    step_cnt_d     = step_cnt_q;
    period_d       = period_q;
    prev_dir_d     = prev_dir_q;
    period_valid_d = 1'b0;
    reverse_d      = 1'b0;
    zero_hit_d     = 1'b0;
    per_cnt_d      = timeout ? per_cnt_q : per_cnt_q + 1'b1;
    if (pins.i_clear) begin
      pos_d      = '0;
      step_cnt_d = '0;
      period_d   = '0;
      per_cnt_d  = '0;
    end else begin
      if (step_rise) begin
        step_cnt_d = step_cnt_q + 1'b1;
        per_cnt_d  = C_CNT_W'(1);
        prev_dir_d = dir_s;
        pos_d      = dir_s ? (pos_q - inc) : (pos_q + inc);
        if (state_q == ST_MOVING) begin
          if (dir_s == prev_dir_q) begin
            period_d       = period_sat;
            period_valid_d = 1'b1;
          end else begin
            reverse_d = 1'b1;
          end
        end
      end
      if (zpd_rise) begin
        pos_d      = '0;
        zero_hit_d = 1'b1;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      pos_q          <= '0;
      step_cnt_q     <= '0;
      period_q       <= '0;
      per_cnt_q      <= '0;
      period_valid_q <= 1'b0;
      reverse_q      <= 1'b0;
      stall_q        <= 1'b0;
      zero_hit_q     <= 1'b0;
      prev_dir_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      pos_q          <= pos_d;
      step_cnt_q     <= step_cnt_d;
      period_q       <= period_d;
      per_cnt_q      <= per_cnt_d;
      period_valid_q <= period_valid_d;
      reverse_q      <= reverse_d;
      stall_q        <= stall_d;
      zero_hit_q     <= zero_hit_d;
      prev_dir_q     <= prev_dir_d;
    end
  end

`ifdef STEP_MON_DIR_CHECK_EN
  localparam int                     C_SETUP_W   = $clog2(C_DIR_SETUP + 1);
  localparam logic [C_SETUP_W-1:0]   C_SETUP_MAX = C_SETUP_W'(C_DIR_SETUP);

  logic                 dir_dly_q;
  logic [C_SETUP_W-1:0] setup_cnt_q, setup_cnt_d;
  logic                 dir_err_q, dir_err_d;
  logic                 dir_chg;

  assign dir_chg = dir_s ^ dir_dly_q;

  // Dir stability count; a step on a freshly changed dir latches the error
  always_comb begin
    setup_cnt_d = setup_cnt_q;
    dir_err_d   = dir_err_q;
    if (dir_chg) begin
      setup_cnt_d = '0;
    end else if (setup_cnt_q != C_SETUP_MAX) begin
      setup_cnt_d = setup_cnt_q + 1'b1;
    end
    if (pins.i_clear) begin
      dir_err_d = 1'b0;
    end else if (step_rise && (dir_chg || (setup_cnt_q < C_SETUP_MAX))) begin
      dir_err_d = 1'b1;
    end
  end

  // Dir-check registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dir_dly_q   <= 1'b0;
      setup_cnt_q <= '0;
      dir_err_q   <= 1'b0;
    end else begin
      dir_dly_q   <= dir_s;
      setup_cnt_q <= setup_cnt_d;
      dir_err_q   <= dir_err_d;
    end
  end

  assign pins.o_dir_err = dir_err_q;
`else
  assign pins.o_dir_err = 1'b0;
`endif

  assign pins.o_position     = pos_q;
  assign pins.o_step_cnt     = step_cnt_q;
  assign pins.o_period       = period_q;
  assign pins.o_period_valid = period_valid_q;
  assign pins.o_moving       = (state_q == ST_MOVING);
  assign pins.o_reverse      = reverse_q;
  assign pins.o_stall        = stall_q;
  assign pins.o_zero_hit     = zero_hit_q;

endmodule
`default_nettype wire

// File: tb/tb_step_pulse_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_step_pulse_monitor
// Description : Self-checking bench for step_pulse_monitor. It uses a table of
//               step bursts with expected results, queued and compared after
//               each burst, plus hand sequences for latency, stall, zero hit,
//               dir setup and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_step_pulse_monitor;
  localparam int PW = 32, SW = 16, PERW = 16, MSW = 3;
`ifdef STEP_MON_DIR_CHECK_EN
  localparam bit DIR_CHK = 1'b1;
`else
  localparam bit DIR_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  step_pulse_monitor_if #(.C_POSITION_WIDTH(PW), .C_STEP_NUMBER_WIDTH(SW),
                          .C_PERIOD_WIDTH(PERW), .C_MICROSTEP_WIDTH(MSW)) pins ();

  step_pulse_monitor #(
    .C_POSITION_WIDTH(PW), .C_STEP_NUMBER_WIDTH(SW), .C_PERIOD_WIDTH(PERW),
    .C_MICROSTEP_WIDTH(MSW), .C_MS_MAX(5), .C_SYNC_STAGES(2),
    .C_STALL_CYCLES(50000), .C_DIR_SETUP(4)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .pins(pins)
  );

  typedef struct {
    bit clr; int n; int gap; bit dir; int ms; int pre;
    int exp_pos; int exp_cnt; int exp_pv; int exp_period; int exp_rev; bit exp_mov;
  } vec_t;

  vec_t vecs[6];
  vec_t sbq[$];

  int n_vec = 0;
  int n_err = 0;
  int pv_seen = 0, rev_seen = 0, stall_seen = 0, zh_seen = 0;
  bit pv_prev = 0, rev_prev = 0, stall_prev = 0, zh_prev = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [63:0] p64(int x);
    logic [31:0] t;
    t = x;
    return {32'h0, t};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(int gap);
    pins.i_drive = 1'b1;
    tick();
    tick();
    pins.i_drive = 1'b0;
    repeat (gap - 2) tick();
  endtask

  task automatic do_clear();
    pins.i_clear = 1'b1;
    tick();
    pins.i_clear = 1'b0;
    tick();
  endtask

  // Strobe counting, with a width check on every observed strobe
  always @(negedge clk) begin
    if (pins.o_period_valid) begin pv_seen++;    chk("period_valid width", 64'(pv_prev), 64'(0));    end
    if (pins.o_reverse)      begin rev_seen++;   chk("reverse width", 64'(rev_prev), 64'(0));        end
    if (pins.o_stall)        begin stall_seen++; chk("stall width", 64'(stall_prev), 64'(0));        end
    if (pins.o_zero_hit)     begin zh_seen++;    chk("zero_hit width", 64'(zh_prev), 64'(0));        end
    pv_prev    = pins.o_period_valid;
    rev_prev   = pins.o_reverse;
    stall_prev = pins.o_stall;
    zh_prev    = pins.o_zero_hit;
  end

  initial begin
    #900us;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    vec_t v, e;
    bit   got;
    //           clr  n  gap dir ms pre   pos cnt pv per rev mov
    vecs[0] = '{1'b1, 10, 100, 1'b0, 5, 10,  10, 10, 9, 100, 0, 1'b1};
    vecs[1] = '{1'b1,  3,  20, 1'b0, 0, 10,  96,  3, 2,  20, 0, 1'b1};
    vecs[2] = '{1'b0,  1,  20, 1'b1, 0, 10,  64,  4, 0,  20, 1, 1'b1};
    vecs[3] = '{1'b1,  4,  30, 1'b1, 3, 10, -16,  4, 3,  30, 0, 1'b1};
    vecs[4] = '{1'b1,  5,   7, 1'b0, 7, 10,   5,  5, 4,   7, 0, 1'b1};
    vecs[5] = '{1'b0,  3,  12, 1'b1, 4, 10,  -1,  8, 2,  12, 1, 1'b1};

    pins.i_drive = 1'b0; pins.i_dir = 1'b0; pins.i_ms = 3'd5;
    pins.i_zpd = 1'b0;   pins.i_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset position", 64'(pins.o_position), 64'(0));
    chk("reset step_cnt", 64'(pins.o_step_cnt), 64'(0));
    chk("reset period",   64'(pins.o_period), 64'(0));
    chk("reset moving",   64'(pins.o_moving), 64'(0));
    chk("reset dir_err",  64'(pins.o_dir_err), 64'(0));
    resetn = 1'b1;
    repeat (10) tick();

    // Latency: rise first sampled at edge k shows up at edge k+2
    pins.i_drive = 1'b1;
    tick();
    chk("latency k", 64'(pins.o_step_cnt), 64'(0));
    tick();
    chk("latency k+1", 64'(pins.o_step_cnt), 64'(0));
    tick();
    chk("latency k+2 cnt", 64'(pins.o_step_cnt), 64'(1));
    chk("latency k+2 pos", 64'(pins.o_position), p64(1));
    chk("latency k+2 moving", 64'(pins.o_moving), 64'(1));
    pins.i_drive = 1'b0;
    repeat (5) tick();

    // Table-driven bursts
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      if (v.clr) do_clear();
      pins.i_dir = v.dir;
      pins.i_ms  = 3'(v.ms);
      sbq.push_back(v);
      pv_seen = 0; rev_seen = 0;
      repeat (v.pre) tick();
      for (int k = 0; k < v.n; k++) pulse(v.gap);
      repeat (4) tick();
      e = sbq.pop_front();
      chk($sformatf("v%0d position", i), 64'(pins.o_position), p64(e.exp_pos));
      chk($sformatf("v%0d step_cnt", i), 64'(pins.o_step_cnt), 64'(e.exp_cnt));
      chk($sformatf("v%0d period_valid count", i), 64'(pv_seen), 64'(e.exp_pv));
      if (e.exp_pv > 0) chk($sformatf("v%0d period", i), 64'(pins.o_period), 64'(e.exp_period));
      chk($sformatf("v%0d reverse count", i), 64'(rev_seen), 64'(e.exp_rev));
      chk($sformatf("v%0d moving", i), 64'(pins.o_moving), 64'(e.exp_mov));
    end

    // Stall after the last burst, then a restart reports no period
    stall_seen = 0; pv_seen = 0; got = 1'b0;
    for (int c = 0; c < 60000 && !got; c++) begin
      tick();
      if (pins.o_stall) got = 1'b1;
    end
    chk("stall seen", 64'(got), 64'(1));
    chk("stall moving", 64'(pins.o_moving), 64'(0));
    tick();
    chk("stall strobe drop", 64'(pins.o_stall), 64'(0));
    chk("stall count", 64'(stall_seen), 64'(1));
    pulse(20);
    repeat (4) tick();
    chk("restart period_valid", 64'(pv_seen), 64'(0));
    chk("restart moving", 64'(pins.o_moving), 64'(1));
    chk("restart position", 64'(pins.o_position), p64(-3));
    chk("restart step_cnt", 64'(pins.o_step_cnt), 64'(9));

    // Zero detector coincident with a step at position 500
    do_clear();
    pins.i_dir = 1'b0; pins.i_ms = 3'd0;
    repeat (10) tick();
    for (int k = 0; k < 15; k++) pulse(4);
    pins.i_ms = 3'd2;
    pulse(4); pulse(4);
    pins.i_ms = 3'd3;
    pulse(4);
    repeat (4) tick();
    chk("zpd pre position", 64'(pins.o_position), p64(500));
    chk("zpd pre step_cnt", 64'(pins.o_step_cnt), 64'(18));
    zh_seen = 0;
    pins.i_zpd = 1'b1;
    pulse(8);
    chk("zpd position", 64'(pins.o_position), p64(0));
    chk("zpd step_cnt", 64'(pins.o_step_cnt), 64'(19));
    chk("zpd zero_hit count", 64'(zh_seen), 64'(1));
    pins.i_zpd = 1'b0;
    repeat (6) tick();
    chk("zpd release zero_hit", 64'(zh_seen), 64'(1));

    // Dir toggled two clocks before a step
    do_clear();
    pins.i_dir = 1'b0; pins.i_ms = 3'd5;
    repeat (10) tick();
    pulse(10);
    chk("dir_err before toggle", 64'(pins.o_dir_err), 64'(0));
    pins.i_ms = 3'd4;
    pins.i_dir = 1'b1;
    tick(); tick();
    pulse(10);
    repeat (4) tick();
    chk("dir_err set", 64'(pins.o_dir_err), 64'(DIR_CHK));
    chk("dir_err step counted", 64'(pins.o_step_cnt), 64'(2));
    chk("dir_err new dir used", 64'(pins.o_position), p64(-1));
    repeat (20) tick();
    chk("dir_err held", 64'(pins.o_dir_err), 64'(DIR_CHK));
    do_clear();
    chk("clear dir_err", 64'(pins.o_dir_err), 64'(0));
    chk("clear position", 64'(pins.o_position), p64(0));
    chk("clear step_cnt", 64'(pins.o_step_cnt), 64'(0));
    chk("clear period", 64'(pins.o_period), 64'(0));
    chk("clear moving", 64'(pins.o_moving), 64'(0));

    // Asynchronous reset while moving at -37
    pins.i_dir = 1'b1; pins.i_ms = 3'd5;
    repeat (10) tick();
    for (int k = 0; k < 37; k++) pulse(3);
    repeat (4) tick();
    chk("pre-reset position", 64'(pins.o_position), p64(-37));
    chk("pre-reset moving", 64'(pins.o_moving), 64'(1));
    #3;
    resetn = 1'b0;
    #1;
    chk("async reset position", 64'(pins.o_position), p64(0));
    chk("async reset step_cnt", 64'(pins.o_step_cnt), 64'(0));
    chk("async reset period", 64'(pins.o_period), 64'(0));
    chk("async reset moving", 64'(pins.o_moving), 64'(0));
    chk("async reset dir_err", 64'(pins.o_dir_err), 64'(0));
    tick();
    resetn = 1'b1;
    pv_seen = 0;
    repeat (10) tick();
    pulse(10);
    repeat (4) tick();
    chk("post-reset moving", 64'(pins.o_moving), 64'(1));
    chk("post-reset step_cnt", 64'(pins.o_step_cnt), 64'(1));
    chk("post-reset position", 64'(pins.o_position), p64(-1));
    chk("post-reset period_valid", 64'(pv_seen), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
